// File: rtl/game_state_controller_if.sv
// Signal bundle between the game-logic side and the round sequencer.
// The sequencer connects through the slave modport.
interface game_state_controller_if;
    logic        frame_tick;
    logic        start_btn;
    logic        pacman_is_dead;
    logic        food_eaten;
    logic        game_rst;
    logic        freeze;
    logic [2:0]  state;
    logic [2:0]  lives;
    logic [11:0] food_count;

    modport master (
        output frame_tick, start_btn, pacman_is_dead, food_eaten,
        input  game_rst, freeze, state, lives, food_count
    );

    modport slave (
        input  frame_tick, start_btn, pacman_is_dead, food_eaten,
        output game_rst, freeze, state, lives, food_count
    );
endinterface

// File: rtl/game_state_controller.sv
// Round-level sequencer: lives, pellet count and the IDLE/READY/PLAY/DYING/
// GAME_OVER/WIN machine that gates the game-logic core via game_rst/freeze.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | core held in reset, waiting for a start press
// READY     | core running but frozen, READY_TICKS frame countdown
// PLAY      | sprites move; counts pellets and watches for death edges
// DYING     | frozen, DYING_TICKS frame countdown, then READY or GAME_OVER
// GAME_OVER | frozen display of final lives/food until start press
// WIN       | frozen display after last pellet until start press
module game_state_controller #(
    parameter logic [2:0]  LIVES       = 3'd3,
    parameter logic [11:0] FOOD_TOTAL  = 12'd1000,
    parameter logic [7:0]  READY_TICKS = 8'd120,
    parameter logic [7:0]  DYING_TICKS = 8'd90
) (
    input  logic                          clk,
    input  logic                          rst,
    game_state_controller_if.slave        gsc
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READY     = 3'd1,
        S_PLAY      = 3'd2,
        S_DYING     = 3'd3,
        S_GAME_OVER = 3'd4,
        S_WIN       = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_game_rst;
    logic        r_freeze;
    logic [2:0]  r_lives;
    logic [11:0] r_food_count;
    logic [7:0]  r_timer;
    logic        r_start_q;
    logic        r_dead_q;

    state_t      w_state_nxt;
    logic [2:0]  w_lives_nxt;
    logic [11:0] w_food_nxt;
    logic [11:0] w_food_inc;
    logic [7:0]  w_timer_nxt;
    logic        w_start_rise;
    logic        w_dead_rise;
    logic        w_timer_last;

    assign w_start_rise = gsc.start_btn & ~r_start_q;
    assign w_dead_rise  = gsc.pacman_is_dead & ~r_dead_q;
    assign w_timer_last = (r_timer == 8'd1);
    assign w_food_inc   = r_food_count + 12'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_food_nxt  = r_food_count;
        w_timer_nxt = r_timer;

        case (r_state)
            S_IDLE: begin
                w_lives_nxt = LIVES;
                w_food_nxt  = 12'd0;
                if (w_start_rise) begin
                    w_state_nxt = S_READY;
                    w_timer_nxt = READY_TICKS;
                end
            end

            S_READY: begin
                if (gsc.frame_tick) begin
                    if (w_timer_last) begin
                        w_state_nxt = S_PLAY;
                    end else begin
                        w_timer_nxt = r_timer - 8'd1;
                    end
                end
            end

            S_PLAY: begin
                if (gsc.food_eaten && (r_food_count != FOOD_TOTAL)) begin
                    w_food_nxt = w_food_inc;
                end
                // The completing pellet wins even if a death edge lands on the same cycle.
                if (gsc.food_eaten && (w_food_inc == FOOD_TOTAL)) begin
                    w_state_nxt = S_WIN;
                end else if (w_dead_rise) begin
                    w_lives_nxt = r_lives - 3'd1;
                    w_state_nxt = S_DYING;
                    w_timer_nxt = DYING_TICKS;
                end
            end

            S_DYING: begin
                if (gsc.frame_tick) begin
                    if (w_timer_last) begin
                        if (r_lives == 3'd0) begin
                            w_state_nxt = S_GAME_OVER;
                        end else begin
                            w_state_nxt = S_READY;
                            w_timer_nxt = READY_TICKS;
                        end
                    end else begin
                        w_timer_nxt = r_timer - 8'd1;
                    end
                end
            end

            S_GAME_OVER, S_WIN: begin
                if (w_start_rise) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_game_rst   <= 1'b1;
            r_freeze     <= 1'b1;
            r_lives      <= LIVES;
            r_food_count <= 12'd0;
            r_timer      <= 8'd0;
            r_start_q    <= 1'b1;
            r_dead_q     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_game_rst   <= (w_state_nxt == S_IDLE);
            r_freeze     <= (w_state_nxt != S_PLAY);
            r_lives      <= w_lives_nxt;
            r_food_count <= w_food_nxt;
            r_timer      <= w_timer_nxt;
            r_start_q    <= gsc.start_btn;
            r_dead_q     <= gsc.pacman_is_dead;
        end
    end

    assign gsc.state      = r_state;
    assign gsc.game_rst   = r_game_rst;
    assign gsc.freeze     = r_freeze;
    assign gsc.lives      = r_lives;
    assign gsc.food_count = r_food_count;

endmodule
